// File: rtl/mine_placer.sv
`default_nettype none
// ============================================================================
// mine_placer : places N unique mines on a ROWS x COLS board using LFSR
//               rejection sampling; optional macro SAFE_NEIGHBOURHOOD_EN
//               protects the safe cell's 8-neighbourhood too.
// Revision    : 1.0
// ============================================================================
module mine_placer #(
  parameter  int ROWS  = 5,
  parameter  int COLS  = 5,
  localparam int CELLS = ROWS * COLS,
  localparam int IDX_W = $clog2(CELLS),
  localparam int CNT_W = $clog2(CELLS + 1)
) (
  input  logic             in_clka,
  input  logic             in_reset,
  input  logic             in_start,
  input  logic [15:0]      in_seed,
  input  logic [CNT_W-1:0] in_mines_num,
  input  logic [IDX_W-1:0] in_safe_idx,
  output logic             out_busy,
  output logic             out_place_done,
  output logic             out_clamped,
  output logic [CNT_W-1:0] out_mine_count,
  output logic [CELLS-1:0] out_mines
);
  localparam logic [IDX_W:0]   CELLS_I = (IDX_W + 1)'(CELLS);
  localparam logic [CNT_W-1:0] CELLS_C = CNT_W'(CELLS);

  typedef enum logic [1:0] {IDLE = 2'd0, PLACE = 2'd1, DONE = 2'd2} state_t;
  state_t state, state_nx;

  logic [15:0]      lfsr;
  logic [15:0]      lfsr_nx;
  logic [IDX_W-1:0] cand;
  logic [CELLS-1:0] cand_bit;
  logic             cand_on_board;
  logic             excluded;
  logic             accept;
  logic             last;
  logic             start_ok;
  logic [CNT_W-1:0] target;
  logic [CNT_W-1:0] excl_n;
  logic [CNT_W-1:0] max_mines;
  logic [CNT_W-1:0] req_target;

  assign lfsr_nx       = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  assign cand          = lfsr[IDX_W-1:0];
  assign cand_bit      = {{(CELLS - 1){1'b0}}, 1'b1} << cand;
  assign cand_on_board = {1'b0, cand} < CELLS_I;

`ifdef SAFE_NEIGHBOURHOOD_EN
  localparam logic [IDX_W-1:0] COLS_I   = IDX_W'(COLS);
  localparam logic [IDX_W-1:0] ROW_LAST = IDX_W'(ROWS - 1);
  localparam logic [IDX_W-1:0] COL_LAST = IDX_W'(COLS - 1);
  localparam logic [IDX_W:0]   ONE_I    = (IDX_W + 1)'(1);

  logic [IDX_W-1:0] req_row, req_col, safe_row, safe_col, cand_row, cand_col;
  logic [3:0]       span_r, span_c;
  logic             safe_valid, row_near, col_near;

  assign req_row  = in_safe_idx / COLS_I;
  assign req_col  = in_safe_idx % COLS_I;
  // Neighbourhood size is the product of the in-board row span and col span.
  assign span_r   = 4'd1 + {3'b0, req_row != '0} + {3'b0, req_row != ROW_LAST};
  assign span_c   = 4'd1 + {3'b0, req_col != '0} + {3'b0, req_col != COL_LAST};
  assign excl_n   = ({1'b0, in_safe_idx} < CELLS_I) ? CNT_W'(span_r * span_c) : '0;

  assign cand_row = cand / COLS_I;
  assign cand_col = cand % COLS_I;
  assign row_near = ({1'b0, cand_row} + ONE_I >= {1'b0, safe_row}) &&
                    ({1'b0, cand_row} <= {1'b0, safe_row} + ONE_I);
  assign col_near = ({1'b0, cand_col} + ONE_I >= {1'b0, safe_col}) &&
                    ({1'b0, cand_col} <= {1'b0, safe_col} + ONE_I);
  assign excluded = safe_valid && row_near && col_near;

  always_ff @(posedge in_clka or posedge in_reset) begin
    if (in_reset) begin
      safe_row   <= '0;
      safe_col   <= '0;
      safe_valid <= 1'b0;
    end else if (start_ok) begin
      safe_row   <= req_row;
      safe_col   <= req_col;
      safe_valid <= {1'b0, in_safe_idx} < CELLS_I;
    end
  end
`else
  logic [IDX_W-1:0] safe_q;

  // An off-board safe index never matches an on-board candidate.
  assign excl_n   = CNT_W'({1'b0, in_safe_idx} < CELLS_I);
  assign excluded = (cand == safe_q);

  always_ff @(posedge in_clka or posedge in_reset) begin
    if (in_reset) begin
      safe_q <= '0;
    end else if (start_ok) begin
      safe_q <= in_safe_idx;
    end
  end
`endif

  assign max_mines  = CELLS_C - excl_n;
  assign req_target = (in_mines_num > max_mines) ? max_mines : in_mines_num;
  assign start_ok   = in_start && (state != PLACE);
  assign accept     = (state == PLACE) && cand_on_board &&
                      !(|(out_mines & cand_bit)) && !excluded;
  assign last       = accept && (out_mine_count + CNT_W'(1) == target);

  always_ff @(posedge in_clka or posedge in_reset) begin
    if (in_reset) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: if (in_start) state_nx = (req_target == '0) ? DONE : PLACE;
      PLACE:      if (last)     state_nx = DONE;
      default:    state_nx = IDLE;
    endcase
  end

  always_ff @(posedge in_clka or posedge in_reset) begin
    if (in_reset) begin
      lfsr           <= 16'h0001;
      target         <= '0;
      out_clamped    <= 1'b0;
      out_mine_count <= '0;
      out_mines      <= '0;
    end else if (start_ok) begin
      lfsr           <= (in_seed == 16'h0000) ? 16'h0001 : in_seed;
      target         <= req_target;
      out_clamped    <= in_mines_num > max_mines;
      out_mine_count <= '0;
      out_mines      <= '0;
    end else if (state == PLACE) begin
      lfsr <= lfsr_nx;
      if (accept) begin
        out_mines      <= out_mines | cand_bit;
        out_mine_count <= out_mine_count + CNT_W'(1);
      end
    end
  end

  assign out_busy       = (state == PLACE);
  assign out_place_done = (state == DONE);

endmodule
`default_nettype wire

// File: doc/mine_placer.md
Name: mine_placer

Overview:
Parametrised successor to the single-shot mine RNG. Places exactly N unique mines on a ROWS x COLS board.
- Candidates come from a 16-bit maximal LFSR with rejection sampling: no modulo, no duplicates, never on the player's safe cell.
- Sits between the game-control FSM, which issues the start, seed and mine count, and the board/neighbour-count logic, which consumes out_mines.

Parameters:
ROWS, 5, board rows (>=2)
COLS, 5, board columns (>=2)
CELLS, ROWS*COLS, localparam; cell count (<=32768)
IDX_W, $clog2(CELLS), localparam; cell index width
CNT_W, $clog2(CELLS+1), localparam; mine count width

Ports:
in_clka  input  1  clock, all state updates on rising edge
in_reset  input  1  asynchronous, active-high reset
in_start  input  1  one-cycle request to generate a new map
in_seed  input  16  LFSR seed, sampled with in_start
in_mines_num  input  CNT_W  requested mine count, sampled with in_start
in_safe_idx  input  IDX_W  row-major index of the protected cell (row*COLS+col), sampled with in_start
out_busy  output  1  high while placing
out_place_done  output  1  level; map valid and stable
out_clamped  output  1  request exceeded the legal maximum and was reduced
out_mine_count  output  CNT_W  mines placed so far
out_mines  output  CELLS  bit i = 1 means cell i holds a mine

Behaviour:
- Reset (async assert, sync release): FSM=IDLE, LFSR=16'h0001, all outputs 0.
- LFSR: Fibonacci, taps 16,14,13,11, shifts left, feedback into bit 0. Seed 0 is replaced by 16'h0001.
- Candidate = lfsr[IDX_W-1:0].
  - Because 16 > IDX_W, every index appears within one 65535-cycle period.
  - Placement of each mine is therefore guaranteed to terminate.
- Excluded set E: {in_safe_idx}. max_mines = CELLS - |E|. If in_safe_idx >= CELLS, E is empty.
- target = min(in_mines_num, max_mines). out_clamped = (in_mines_num > max_mines), held until the next accepted start.
- States: IDLE, PLACE, DONE.
- IDLE/DONE + in_start=1, at the edge:
  - Clear out_mines, out_mine_count and out_place_done.
  - Load the seed and the captured safe index.
  - Compute target and out_clamped.
  - If target==0: go to DONE with out_place_done=1 on the next cycle.
  - Otherwise: go to PLACE with out_busy=1.
- PLACE, every cycle:
  - Accept the candidate if candidate < CELLS, out_mines[candidate]==0 and candidate not in E.
  - On accept: set the bit and increment out_mine_count.
  - The LFSR advances every PLACE cycle regardless of accept.
  - When the accept makes count == target: go to DONE. Next cycle out_busy=0 and out_place_done=1.
- in_start while in PLACE is ignored; there is no queueing and sampled inputs do not change.
- DONE holds the map until the next in_start or reset.
- Reset asserted mid-PLACE clears everything immediately. No partial map survives.
- Determinism: identical (seed, mines_num, safe_idx) always yields an identical out_mines and an identical cycle count.

Optional Feature:
SAFE_NEIGHBOURHOOD_EN
- Defined: E becomes the safe cell plus its in-board 8-neighbours. That is 9 cells interior, 6 on an edge, 4 in a corner. max_mines shrinks accordingly, so the first click always opens a zero-count region.
- Undefined: E is the single safe cell only.
- Neighbour membership is computed combinationally from the captured row/col. No extra latency either way.

Test Plan:
- 5x5, seed 16'hACE1, mines 5, safe 12 -> out_place_done=1, popcount(out_mines)=5, out_mines[12]=0, out_mine_count=5, out_clamped=0.
- Repeat the same start twice -> bit-identical out_mines and identical start-to-done cycle count. Seed 16'h0000 gives the same map as seed 16'h0001.
- mines 30, safe 0 -> out_clamped=1, out_mine_count=24, out_mines=25'h1FFFFFE.
- mines 0 -> out_place_done=1 one cycle after start, out_mines=0, out_busy never asserted.
- Reset pulsed mid-PLACE -> all outputs 0 immediately. A new start with mines 5 afterwards completes normally. A second in_start pulsed during PLACE is ignored, and the map matches the first start's inputs.
- SAFE_NEIGHBOURHOOD_EN defined:
  - safe 12, mines 16 -> cells 6,7,8,11,12,13,16,17,18 all 0, popcount=16.
  - safe 0, mines 25 -> out_mine_count=21, out_clamped=1.
